// File: rtl/bounce_multi_if.sv
// -----------------------------------------------------------------------------
// bounce_multi_if
// Plot-stream and control bundle of the multi-box bouncer.
//   iColour  : 3*N_BOX  per-box colour, box k uses iColour[3k+2:3k]
//   iPause   : 1        hold pending moves, start no new pass
//   oX       : 8        pixel x
//   oY       : 7        pixel y
//   oColour  : 3        pixel colour (0 while erasing)
//   oPlot    : 1        pixel write strobe
//   oBusy    : 1        high whenever the animator is not idle in WAIT
// The master modport is the animator; the slave modport is its consumer.
// -----------------------------------------------------------------------------
interface bounce_multi_if #(
    parameter int N_BOX = 2
);
    logic [3*N_BOX-1:0] iColour;
    logic               iPause;
    logic [7:0]         oX;
    logic [6:0]         oY;
    logic [2:0]         oColour;
    logic               oPlot;
    logic               oBusy;

    modport master (
        input  iColour,
        input  iPause,
        output oX,
        output oY,
        output oColour,
        output oPlot,
        output oBusy
    );

    modport slave (
        output iColour,
        output iPause,
        input  oX,
        input  oY,
        input  oColour,
        input  oPlot,
        input  oBusy
    );
endinterface

// File: rtl/bounce_multi.sv
// -----------------------------------------------------------------------------
// bounce_multi
// Animates N_BOX independently bouncing solid rectangles on a small VGA pixel
// buffer. Each move tick erases every box, moves all boxes by STEP with wall
// reflection and redraws them, producing one pixel write per clock.
//
// Ports:
//   clk     : clock
//   resetn  : synchronous, active-low reset
//   bus     : bounce_multi_if.master (iColour, iPause in; oX, oY, oColour,
//             oPlot, oBusy out; all outputs registered)
//
// Optional build macro:
//   BOUNCE_MULTI_TRAIL_EN : skip the erase pass so boxes leave trails.
// -----------------------------------------------------------------------------
module bounce_multi #(
    parameter int X_SCREENSIZE      = 160,
    parameter int Y_SCREENSIZE      = 120,
    parameter int CLOCKS_PER_SECOND = 5000,
    parameter int MOVES_PER_SECOND  = 4,
    parameter int N_BOX             = 2,
    parameter int X_BOXSIZE         = 4,
    parameter int Y_BOXSIZE         = 4,
    parameter int STEP              = 1
) (
    input  logic           clk,
    input  logic           resetn,
    bounce_multi_if.master bus
);
    localparam int TICK_PERIOD = CLOCKS_PER_SECOND / MOVES_PER_SECOND;
    localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int BOX_W       = (N_BOX > 1) ? $clog2(N_BOX) : 1;
    localparam int unsigned CW = 3;

    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_PERIOD - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO   = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
    localparam logic [3:0]        SX_LAST     = 4'(X_BOXSIZE - 1);
    localparam logic [3:0]        SY_LAST     = 4'(Y_BOXSIZE - 1);
    localparam logic [BOX_W-1:0]  BOX_LAST    = BOX_W'(N_BOX - 1);
    localparam logic [BOX_W-1:0]  BOX_ZERO    = BOX_W'(0);
    localparam logic [BOX_W-1:0]  BOX_ONE     = BOX_W'(1);
    localparam logic [7:0]        X_MAX       = 8'(X_SCREENSIZE - X_BOXSIZE);
    localparam logic [7:0]        Y_MAX       = 8'(Y_SCREENSIZE - Y_BOXSIZE);
    localparam logic [8:0]        STEP9       = 9'(STEP);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_DRAW   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ERASE  = 3'd3,
        ST_UPDATE = 3'd4
    } state_t;

    // One axis of the position update. dir_neg=1 means moving left/up.
    // Returns {new_dir_neg, new_pos}; 9-bit arithmetic keeps pos+STEP from
    // wrapping and lets pos<STEP be detected before subtracting.
    function automatic logic [8:0] axis_next(input logic [7:0] pos,
                                             input logic       dir_neg,
                                             input logic [7:0] lim);
        logic [8:0] pos9;
        logic [8:0] sum9;
        logic [8:0] dif9;
        logic [8:0] res;
        pos9 = {1'b0, pos};
        sum9 = pos9 + STEP9;
        dif9 = pos9 - STEP9;
        if (!dir_neg) begin
            if (sum9 >= {1'b0, lim}) begin
                res = {1'b1, lim};
            end else begin
                res = {1'b0, sum9[7:0]};
            end
        end else begin
            if ((pos9 < STEP9) || (dif9 == 9'd0)) begin
                res = {1'b0, 8'd0};
            end else begin
                res = {1'b1, dif9[7:0]};
            end
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [BOX_W-1:0]   b_r;
    logic [BOX_W-1:0]   b_nxt_s;
    logic [3:0]         sx_r;
    logic [3:0]         sx_nxt_s;
    logic [3:0]         sy_r;
    logic [3:0]         sy_nxt_s;
    logic [TICK_W-1:0]  tick_cnt_r;
    logic               tick_s;
    logic               pending_r;
    logic               go_s;
    logic               start_pass_s;
    logic               do_update_s;
    logic               last_px_s;
    logic               last_box_s;
    logic               first_px_s;
    logic [7:0]         pos_x_r [N_BOX];
    logic [6:0]         pos_y_r [N_BOX];
    logic               dir_x_r [N_BOX];
    logic               dir_y_r [N_BOX];
    logic [8:0]         upd_x_s [N_BOX];
    logic [8:0]         upd_y_s [N_BOX];
    logic [7:0]         cur_x_s;
    logic [6:0]         cur_y_s;
    logic [2:0]         col_s;
    logic [2:0]         col_r;
    logic [7:0]         ox_r;
    logic [6:0]         oy_r;
    logic [2:0]         ocolour_r;
    logic               oplot_r;
    logic               obusy_r;

    assign tick_s     = (tick_cnt_r == TICK_ZERO);
    assign go_s       = (pending_r | tick_s) & ~bus.iPause;
    assign last_px_s  = (sx_r == SX_LAST) && (sy_r == SY_LAST);
    assign last_box_s = (b_r == BOX_LAST);
    assign first_px_s = (sx_r == 4'd0) && (sy_r == 4'd0);
    assign cur_x_s    = pos_x_r[b_r] + {4'd0, sx_r};
    assign cur_y_s    = pos_y_r[b_r] + {3'd0, sy_r};

    // Free-running move tick divider, independent of the FSM and pause
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_cnt_r <= TICK_RELOAD;
        end else if (tick_s) begin
            tick_cnt_r <= TICK_RELOAD;
        end else begin
            tick_cnt_r <= tick_cnt_r - TICK_ONE;
        end
    end

    // Candidate next position/direction of every box (applied in UPDATE)
    always_comb begin
        for (int k = 0; k < N_BOX; k++) begin
            upd_x_s[k] = axis_next(pos_x_r[k], dir_x_r[k], X_MAX);
            upd_y_s[k] = axis_next({1'b0, pos_y_r[k]}, dir_y_r[k], Y_MAX);
        end
    end

    // Pixel colour: latched from iColour on the first pixel of each drawn box
    always_comb begin
        col_s = 3'd0;
        if (state_r == ST_DRAW) begin
            if (first_px_s) begin
                col_s = bus.iColour[CW*b_r +: CW];
            end else begin
                col_s = col_r;
            end
        end else begin
            col_s = 3'd0;
        end
    end

    // FSM next state and raster-scan counter advance
    always_comb begin
        state_nxt_s  = state_r;
        b_nxt_s      = b_r;
        sx_nxt_s     = sx_r;
        sy_nxt_s     = sy_r;
        start_pass_s = 1'b0;
        do_update_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                state_nxt_s = ST_DRAW;
                b_nxt_s     = BOX_ZERO;
                sx_nxt_s    = 4'd0;
                sy_nxt_s    = 4'd0;
            end
            ST_DRAW, ST_ERASE: begin
                if (last_px_s) begin
                    sx_nxt_s = 4'd0;
                    sy_nxt_s = 4'd0;
                    if (last_box_s) begin
                        b_nxt_s     = BOX_ZERO;
                        state_nxt_s = (state_r == ST_DRAW) ? ST_WAIT : ST_UPDATE;
                    end else begin
                        b_nxt_s     = b_r + BOX_ONE;
                    end
                end else if (sx_r == SX_LAST) begin
                    sx_nxt_s = 4'd0;
                    sy_nxt_s = sy_r + 4'd1;
                end else begin
                    sx_nxt_s = sx_r + 4'd1;
                end
            end
            ST_WAIT: begin
                if (go_s) begin
                    start_pass_s = 1'b1;
                    b_nxt_s      = BOX_ZERO;
                    sx_nxt_s     = 4'd0;
                    sy_nxt_s     = 4'd0;
`ifdef BOUNCE_MULTI_TRAIL_EN
                    state_nxt_s  = ST_UPDATE;
`else
                    state_nxt_s  = ST_ERASE;
`endif
                end else begin
                    state_nxt_s  = ST_WAIT;
                end
            end
            ST_UPDATE: begin
                do_update_s = 1'b1;
                state_nxt_s = ST_DRAW;
                b_nxt_s     = BOX_ZERO;
                sx_nxt_s    = 4'd0;
                sy_nxt_s    = 4'd0;
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // FSM state, scan counters, pending move flag and box positions
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_INIT;
            b_r       <= BOX_ZERO;
            sx_r      <= 4'd0;
            sy_r      <= 4'd0;
            pending_r <= 1'b0;
            col_r     <= 3'd0;
            for (int k = 0; k < N_BOX; k++) begin
                pos_x_r[k] <= 8'(16 * k);
                pos_y_r[k] <= 7'(8 * k);
                dir_x_r[k] <= ((k % 2) == 1);
                dir_y_r[k] <= 1'b0;
            end
        end else begin
            state_r <= state_nxt_s;
            b_r     <= b_nxt_s;
            sx_r    <= sx_nxt_s;
            sy_r    <= sy_nxt_s;
            col_r   <= col_s;
            // A tick landing while a move is already queued is dropped
            if (start_pass_s) begin
                pending_r <= 1'b0;
            end else if (tick_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
            if (do_update_s) begin
                for (int k = 0; k < N_BOX; k++) begin
                    pos_x_r[k] <= upd_x_s[k][7:0];
                    dir_x_r[k] <= upd_x_s[k][8];
                    pos_y_r[k] <= upd_y_s[k][6:0];
                    dir_y_r[k] <= upd_y_s[k][8];
                end
            end else begin
                for (int k = 0; k < N_BOX; k++) begin
                    pos_x_r[k] <= pos_x_r[k];
                    dir_x_r[k] <= dir_x_r[k];
                    pos_y_r[k] <= pos_y_r[k];
                    dir_y_r[k] <= dir_y_r[k];
                end
            end
        end
    end

    // Output stage: pixel registered one cycle behind the scan counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ox_r      <= 8'd0;
            oy_r      <= 7'd0;
            ocolour_r <= 3'd0;
            oplot_r   <= 1'b0;
            obusy_r   <= 1'b1;
        end else begin
            ox_r      <= cur_x_s;
            oy_r      <= cur_y_s;
            ocolour_r <= col_s;
            oplot_r   <= (state_r == ST_DRAW) || (state_r == ST_ERASE);
            obusy_r   <= (state_r != ST_WAIT);
        end
    end

    assign bus.oX      = ox_r;
    assign bus.oY      = oy_r;
    assign bus.oColour = ocolour_r;
    assign bus.oPlot   = oplot_r;
    assign bus.oBusy   = obusy_r;
endmodule

// File: tb/tb_bounce_multi.sv
// -----------------------------------------------------------------------------
// tb_bounce_multi
// dut0: default parameters (timing, first move, pause, mid-erase reset).
// dut1: 20x13 screen, 2x2 box, STEP=3, fast ticks (wall reflection).
// Expected pixels are pushed into per-DUT queues and popped on every oPlot.
// -----------------------------------------------------------------------------
module tb_bounce_multi;
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic resetn0;
    logic resetn1;
    int   checks;
    int   failures;
    int   plots0;
    int   plots1;
    int   cyc;
    pix_t sb0[$];
    pix_t sb1[$];

    always #5 clk = ~clk;

    bounce_multi_if #(.N_BOX(2)) bus0 ();
    bounce_multi_if #(.N_BOX(1)) bus1 ();

    bounce_multi dut0 (
        .clk    (clk),
        .resetn (resetn0),
        .bus    (bus0)
    );

    bounce_multi #(
        .X_SCREENSIZE      (20),
        .Y_SCREENSIZE      (13),
        .CLOCKS_PER_SECOND (40),
        .MOVES_PER_SECOND  (4),
        .N_BOX             (1),
        .X_BOXSIZE         (2),
        .Y_BOXSIZE         (2),
        .STEP              (3)
    ) dut1 (
        .clk    (clk),
        .resetn (resetn1),
        .bus    (bus1)
    );

    // Scoreboard for dut0: every plotted pixel must match the queue head
    always @(negedge clk) begin
        pix_t act;
        pix_t exp;
        if (bus0.oPlot === 1'b1) begin
            plots0++;
            checks++;
            assert (sb0.size() != 0) else begin
                failures++;
                $error("FAIL sb0_empty got pixel x=%0d y=%0d c=%0d want none", bus0.oX, bus0.oY, bus0.oColour);
            end
            if (sb0.size() != 0) begin
                exp = sb0.pop_front();
                act = {bus0.oX, bus0.oY, bus0.oColour};
                checks++;
                assert (act === exp) else begin
                    failures++;
                    $error("FAIL pix0 #%0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                           plots0, act.x, act.y, act.c, exp.x, exp.y, exp.c);
                end
            end
        end
    end

    // Scoreboard for dut1: pixels past the end of the table are ignored
    always @(negedge clk) begin
        pix_t act;
        pix_t exp;
        if (bus1.oPlot === 1'b1) begin
            plots1++;
            if (sb1.size() != 0) begin
                exp = sb1.pop_front();
                act = {bus1.oX, bus1.oY, bus1.oColour};
                checks++;
                assert (act === exp) else begin
                    failures++;
                    $error("FAIL pix1 #%0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                           plots1, act.x, act.y, act.c, exp.x, exp.y, exp.c);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // First n pixels of a 4x4 box at (x,y), raster order
    task automatic push0(input int x, input int y, input logic [2:0] c, input int n);
        pix_t p;
        for (int i = 0; i < n; i++) begin
            p.x = 8'(x + i % 4);
            p.y = 7'(y + i / 4);
            p.c = c;
            sb0.push_back(p);
        end
    endtask

    // Full 2x2 box at (x,y)
    task automatic push1(input int x, input int y, input logic [2:0] c);
        pix_t p;
        for (int i = 0; i < 4; i++) begin
            p.x = 8'(x + i % 2);
            p.y = 7'(y + i / 2);
            p.c = c;
            sb1.push_back(p);
        end
    endtask

    task automatic adv_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int xs[10];
        int ys[10];
        int base;
        int guard;
        xs = '{0, 3, 6, 9, 12, 15, 18, 15, 12, 9};
        ys = '{0, 3, 6, 9, 11, 8, 5, 2, 0, 3};
        checks   = 0;
        failures = 0;
        plots0   = 0;
        plots1   = 0;
        cyc      = 0;
        resetn0  = 1'b0;
        resetn1  = 1'b0;
        bus0.iColour = 6'b011_110;
        bus0.iPause  = 1'b0;
        bus1.iColour = 3'b101;
        bus1.iPause  = 1'b0;

        push0(0, 0, 3'd6, 16);
        push0(16, 8, 3'd3, 16);
        repeat (3) @(posedge clk);
        #1;
        // cycle 0: last reset edge has just been applied
        chk("rst_plot", 32'(bus0.oPlot), 32'd0);
        chk("rst_x", 32'(bus0.oX), 32'd0);
        chk("rst_y", 32'(bus0.oY), 32'd0);
        chk("rst_colour", 32'(bus0.oColour), 32'd0);
        chk("rst_busy", 32'(bus0.oBusy), 32'd1);
        resetn0 = 1'b1;

        adv_to(1);
        chk("init_plot_c1", 32'(bus0.oPlot), 32'd0);
        adv_to(2);
        chk("first_plot_c2", 32'(bus0.oPlot), 32'd1);
        chk("first_colour", 32'(bus0.oColour), 32'd6);
        adv_to(18);
        chk("pix17_x", 32'(bus0.oX), 32'd16);
        chk("pix17_y", 32'(bus0.oY), 32'd8);
        chk("pix17_colour", 32'(bus0.oColour), 32'd3);
        adv_to(33);
        chk("busy_c33", 32'(bus0.oBusy), 32'd1);
        adv_to(34);
        chk("busy_c34", 32'(bus0.oBusy), 32'd0);
        chk("plot_c34", 32'(bus0.oPlot), 32'd0);
        chk("count_init", 32'(plots0), 32'd32);

        // first tick at 1249: erase, update, redraw at moved positions
        push0(0, 0, 3'd0, 16);
        push0(16, 8, 3'd0, 16);
        push0(1, 1, 3'd6, 16);
        push0(15, 9, 3'd3, 16);
        adv_to(1250);
        chk("idle_c1250", 32'(bus0.oPlot), 32'd0);
        chk("count_c1250", 32'(plots0), 32'd32);
        adv_to(1251);
        chk("erase_plot", 32'(bus0.oPlot), 32'd1);
        chk("erase_colour", 32'(bus0.oColour), 32'd0);
        chk("erase_busy", 32'(bus0.oBusy), 32'd1);
        adv_to(1283);
        chk("update_gap", 32'(bus0.oPlot), 32'd0);
        adv_to(1284);
        chk("redraw_x", 32'(bus0.oX), 32'd1);
        chk("redraw_y", 32'(bus0.oY), 32'd1);
        adv_to(1316);
        chk("busy_c1316", 32'(bus0.oBusy), 32'd0);
        chk("count_move1", 32'(plots0), 32'd96);

        // pause across ticks 2499, 3749, 4999: exactly one pass on release
        bus0.iPause = 1'b1;
        push0(1, 1, 3'd0, 16);
        push0(15, 9, 3'd0, 16);
        push0(2, 2, 3'd6, 16);
        push0(14, 10, 3'd3, 16);
        adv_to(5100);
        chk("paused_count", 32'(plots0), 32'd96);
        chk("paused_busy", 32'(bus0.oBusy), 32'd0);
        bus0.iPause = 1'b0;
        adv_to(5102);
        chk("unpause_plot", 32'(bus0.oPlot), 32'd1);
        adv_to(5167);
        chk("unpause_busy", 32'(bus0.oBusy), 32'd0);
        adv_to(6250);
        chk("one_pass_only", 32'(plots0), 32'd160);

        // reset in the middle of the erase started by tick 6249
        push0(2, 2, 3'd0, 10);
        push0(0, 0, 3'd6, 16);
        push0(16, 8, 3'd3, 16);
        adv_to(6260);
        resetn0 = 1'b0;
        adv_to(6261);
        resetn0 = 1'b1;
        base = cyc;
        chk("midrst_plot", 32'(bus0.oPlot), 32'd0);
        chk("midrst_busy", 32'(bus0.oBusy), 32'd1);
        chk("midrst_count", 32'(plots0), 32'd170);
        adv_to(base + 2);
        chk("redraw_first_x", 32'(bus0.oX), 32'd0);
        chk("redraw_first_y", 32'(bus0.oY), 32'd0);
        adv_to(base + 34);
        chk("redraw_busy", 32'(bus0.oBusy), 32'd0);
        chk("redraw_count", 32'(plots0), 32'd202);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);

        // dut1: reflection at both walls with STEP=3
        push1(xs[0], ys[0], 3'd5);
        for (int i = 1; i < 10; i++) begin
            push1(xs[i-1], ys[i-1], 3'd0);
            push1(xs[i], ys[i], 3'd5);
        end
        resetn1 = 1'b1;
        guard = 0;
        while ((plots1 < 76) && (guard < 2000)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("dut1_reached", 32'(plots1 >= 76), 32'd1);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bounce_multi.md
Name: bounce_multi

Overview:
- Animates N_BOX independently bouncing solid rectangles on the 160x120 VGA pixel buffer.
- Emits one pixel write per clock on an (oX, oY, oColour, oPlot) stream that connects directly to the VGA adapter's plot port.
- On each move tick: erases every box, advances all positions by STEP with wall reflection, then redraws every box.
- Parametrised successor to the single-box bouncer: box count, box size, step and move rate are configurable, and the block adds pause and busy handshakes.

Parameters:
- X_SCREENSIZE, 160, screen width in pixels.
- Y_SCREENSIZE, 120, screen height in pixels.
- CLOCKS_PER_SECOND, 5000, clk frequency in Hz.
- MOVES_PER_SECOND, 4, move ticks per second; TICK_PERIOD = CLOCKS_PER_SECOND/MOVES_PER_SECOND.
- N_BOX, 2, number of boxes; legal range 1..8.
- X_BOXSIZE, 4, box width; legal range 1..16.
- Y_BOXSIZE, 4, box height; legal range 1..16.
- STEP, 1, pixels moved per tick on each axis; legal range 1..8.
- Derived: X_MAX = X_SCREENSIZE-X_BOXSIZE, Y_MAX = Y_SCREENSIZE-Y_BOXSIZE.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- iColour  in  3*N_BOX  box k colour is iColour[3k+2:3k]; sampled when box k's draw pass starts.
- iPause  in  1  while high, pending ticks are held and no new pass starts.
- oX  out  8  pixel x.
- oY  out  7  pixel y.
- oColour  out  3  pixel colour; 0 (black) during erase.
- oPlot  out  1  pixel write strobe.
- oBusy  out  1  high in every state except WAIT.

Behaviour:
- Reset: applies on any clk edge with resetn=0, including mid-pass. On the next cycle:
  - oPlot=0, oX=0, oY=0, oColour=0, oBusy=1; state=INIT; pending=0; tick counter=TICK_PERIOD-1.
  - Box k position = (16k, 8k).
  - Box k dirX = right when k is even, left when k is odd; dirY = down.
- Tick counter: counts down each cycle and reloads TICK_PERIOD-1 after reaching 0. tick=1 on the cycle the count is 0. The counter runs free, independent of FSM state and iPause.
- pending flag: set by tick, cleared when an ERASE pass starts. A tick that arrives while pending=1 is dropped, so at most one move is queued.
- FSM states:
  - INIT (1 cycle) -> DRAW, box index b=0.
  - DRAW: raster-scans box b, one pixel per cycle. After box N_BOX-1 finishes -> WAIT.
  - WAIT: moves to ERASE with b=0 when (pending | tick) & !iPause.
  - ERASE: scans box b with colour 0. After box N_BOX-1 finishes -> UPDATE.
  - UPDATE (1 cycle): moves all boxes in parallel, then -> DRAW with b=0.
- Scan order within a box: row-major. x runs x0..x0+X_BOXSIZE-1, then y increments and x returns to x0. Each box takes exactly X_BOXSIZE*Y_BOXSIZE cycles with no gap between boxes.
- Output pipeline: outputs are registered, one cycle after the scan counter. oPlot is high exactly on cycles carrying a valid pixel.
- Position update, per axis, using 9-bit intermediate arithmetic:
  - Moving right/down with pos+STEP >= MAX: pos=MAX, direction flips.
  - Moving left/up with pos < STEP, or pos-STEP = 0: pos=0, direction flips.
  - Otherwise pos ±= STEP.
  - A box never leaves [0,X_MAX] x [0,Y_MAX]; no wrap-around.
- Boxes do not interact; overlapping boxes are drawn in index order, so the higher index wins the overlapped pixels.
- iPause mid-pass: has no effect; the current ERASE/UPDATE/DRAW sequence completes.

Optional Feature:
- Macro: BOUNCE_MULTI_TRAIL_EN.
- Defined: the ERASE state is skipped entirely (WAIT -> UPDATE), so boxes leave trails. A pass then takes 1+N_BOX*W*H cycles.
- Undefined: ERASE runs as specified above.

Test Plan:
- Defaults, resetn released at cycle 0 -> oPlot high cycles 2..33 (32 pixels). First pixel is (0,0) colour iColour[2:0]; the 17th pixel is (16,8) colour iColour[5:3]; oBusy falls at cycle 34.
- First tick at cycle 1249 -> 32 black pixels at the old positions, 1 UPDATE cycle, then 32 coloured pixels with box0 at (1,1) and box1 at (15,9).
- Box0 at x=155, moving right, STEP=1 (X_MAX=156) -> next x=156 with dirX flipped; following tick -> x=155.
- STEP=3, box moving up at y=2 -> y=0 with dirY=down; following tick -> y=3.
- iPause=1 across 3 ticks, then released -> exactly one ERASE/UPDATE/DRAW pass, with positions advanced by one STEP only.
- resetn=0 for 1 cycle in the middle of ERASE -> oPlot=0 next cycle, then the INIT redraw at the reset positions; BOUNCE_MULTI_TRAIL_EN build -> no colour-0 pixels ever appear after INIT.
